// File: rtl/multi_debouncer_if.sv
// multi_debouncer_if -- bundle of the per-channel debouncer signals.
//   P    : raw bouncing inputs, driven by the master side
//   Z    : registered debounced levels
//   rise : one-clock pulse when Z[i] goes 0->1
//   fall : one-clock pulse when Z[i] goes 1->0
// The debouncer itself takes the slave modport.
interface multi_debouncer_if #(
   parameter int N = 4
);
   logic [N-1:0] P;
   logic [N-1:0] Z;
   logic [N-1:0] rise;
   logic [N-1:0] fall;

   modport master (output P, input Z, rise, fall);
   modport slave  (input P, output Z, rise, fall);
endinterface

// File: rtl/multi_debouncer.sv
// multi_debouncer -- N independent debounce channels sharing one sample-tick
// prescaler. Each channel synchronizes its raw input through two flops, then
// accepts a new level only after STABLE consecutive ticks of disagreement
// with the current debounced level.
//   clock   : single rising-edge clock
//   reset_n : synchronous active-low reset
//   bus     : multi_debouncer_if.slave (P in; Z, rise, fall out)

// One debounce channel.
module multi_debouncer_lane #(
   parameter int STABLE    = 16,
   parameter bit RESET_VAL = 1'b0
) (
   input  logic clock,
   input  logic reset_n,
   input  logic tick,
   input  logic p,
   output logic z,
   output logic rise,
   output logic fall
);
   localparam int CW = (STABLE > 1) ? $clog2(STABLE) : 1;
   localparam logic [CW-1:0] CMAX = CW'(STABLE - 1);

   logic          s1, s2;
   logic [CW-1:0] cnt;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         s1   <= RESET_VAL;
         s2   <= RESET_VAL;
         z    <= RESET_VAL;
         cnt  <= '0;
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         s1   <= p;
         s2   <= s1;
         rise <= 1'b0;
         fall <= 1'b0;
         // Any agreement restarts the count, tick or not, so short glitches
         // never accumulate.
         if (s2 == z) begin
            cnt <= '0;
         end else if (tick) begin
            if (cnt == CMAX) begin
               // Pulses are registered alongside z so they line up with the
               // first cycle the new level is visible.
               z    <= s2;
               cnt  <= '0;
               rise <= s2;
               fall <= ~s2;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end
endmodule

module multi_debouncer #(
   parameter int N         = 4,
   parameter int STABLE    = 16,
   parameter int TICK_DIV  = 256,
   parameter bit RESET_VAL = 1'b0
) (
   input logic               clock,
   input logic               reset_n,
   multi_debouncer_if.slave  bus
);
   logic         tick;
   logic [N-1:0] z_w, rise_w, fall_w;

   // Free-running prescaler; input activity never restarts it.
   generate
      if (TICK_DIV == 1) begin : g_notick
         assign tick = 1'b1;
      end else begin : g_presc
         localparam int PW = $clog2(TICK_DIV);
         localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
         logic [PW-1:0] presc;

         always_ff @(posedge clock) begin
            if (!reset_n)           presc <= '0;
            else if (presc == PMAX) presc <= '0;
            else                    presc <= presc + 1'b1;
         end

         assign tick = (presc == PMAX);
      end
   endgenerate

   generate
      for (genvar i = 0; i < N; i++) begin : g_lane
         multi_debouncer_lane #(
            .STABLE    (STABLE),
            .RESET_VAL (RESET_VAL)
         ) u_lane (
            .clock   (clock),
            .reset_n (reset_n),
            .tick    (tick),
            .p       (bus.P[i]),
            .z       (z_w[i]),
            .rise    (rise_w[i]),
            .fall    (fall_w[i])
         );
      end
   endgenerate

   assign bus.Z    = z_w;
   assign bus.rise = rise_w;
   assign bus.fall = fall_w;
endmodule

// File: tb/tb_multi_debouncer.sv
module tb_multi_debouncer;
   logic clock = 1'b0;
   logic reset_n = 1'b0;
   logic [3:0] pa = '0, pb = '0;

   always #5 clock = ~clock;

   multi_debouncer_if #(.N(4)) a_if ();
   multi_debouncer_if #(.N(4)) b_if ();
   assign a_if.P = pa;
   assign b_if.P = pb;

   // A: fast config used by the directed cases. B: prescaled, reset level 1.
   multi_debouncer #(.N(4), .STABLE(4), .TICK_DIV(1), .RESET_VAL(1'b0)) dut_a (
      .clock(clock), .reset_n(reset_n), .bus(a_if));
   multi_debouncer #(.N(4), .STABLE(2), .TICK_DIV(8), .RESET_VAL(1'b1)) dut_b (
      .clock(clock), .reset_n(reset_n), .bus(b_if));

   int n_vec = 0;
   int n_err = 0;

   // Reference model: a raw input is seen two edges late; a channel's level
   // flips on the STABLE-th tick of an unbroken run of disagreement.
   int         m_st[2] = '{4, 2};
   int         m_td[2] = '{1, 8};
   logic [3:0] m_rv[2] = '{4'h0, 4'hF};
   logic [3:0] m_s1[2], m_s2[2], m_z[2], m_r[2], m_f[2];
   int         m_run[2][4];
   int         m_k[2];

   task automatic mstep(input int d, input logic rn, input logic [3:0] p);
      bit tk;
      if (!rn) begin
         m_s1[d] = m_rv[d]; m_s2[d] = m_rv[d]; m_z[d] = m_rv[d];
         m_r[d] = '0; m_f[d] = '0; m_k[d] = 0;
         for (int i = 0; i < 4; i++) m_run[d][i] = 0;
      end else begin
         tk = (m_k[d] % m_td[d]) == m_td[d] - 1;
         m_r[d] = '0; m_f[d] = '0;
         for (int i = 0; i < 4; i++) begin
            if (m_s2[d][i] == m_z[d][i]) m_run[d][i] = 0;
            else if (tk) begin
               m_run[d][i]++;
               if (m_run[d][i] == m_st[d]) begin
                  m_z[d][i] = m_s2[d][i];
                  m_run[d][i] = 0;
                  if (m_s2[d][i]) m_r[d][i] = 1'b1; else m_f[d][i] = 1'b1;
               end
            end
         end
         m_s2[d] = m_s1[d];
         m_s1[d] = p;
         m_k[d]++;
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // One clock: model steps on the edge with the same inputs the DUT sees,
   // outputs are compared on the falling edge.
   task automatic cyc();
      @(posedge clock);
      mstep(0, reset_n, pa);
      mstep(1, reset_n, pb);
      @(negedge clock);
      chk("A.Z", a_if.Z, m_z[0]);
      chk("A.rise", a_if.rise, m_r[0]);
      chk("A.fall", a_if.fall, m_f[0]);
      chk("A.excl", a_if.rise & a_if.fall, 0);
      chk("B.Z", b_if.Z, m_z[1]);
      chk("B.rise", b_if.rise, m_r[1]);
      chk("B.fall", b_if.fall, m_f[1]);
      chk("B.excl", b_if.rise & b_if.fall, 0);
   endtask

   initial begin
      int nf, nr;
      @(negedge clock);
      // Reset state
      reset_n = 1'b0; pa = 4'h0; pb = 4'hF;
      repeat (3) cyc();
      chk("rst.A.Z", a_if.Z, 4'h0);
      chk("rst.A.rise", a_if.rise, 4'h0);
      chk("rst.B.Z", b_if.Z, 4'hF);
      chk("rst.B.fall", b_if.fall, 4'h0);

      // Stable edge on A (edge 6) and prescaled fall on B (edge 16)
      reset_n = 1'b1; pa = 4'b0001; pb = 4'b1101;
      for (int e = 1; e <= 20; e++) begin
         cyc();
         if (e == 5)  chk("lat.A.Z5", a_if.Z, 4'h0);
         if (e == 6)  begin chk("lat.A.Z6", a_if.Z, 4'h1); chk("lat.A.rise6", a_if.rise, 4'h1); end
         if (e == 7)  chk("lat.A.rise7", a_if.rise, 4'h0);
         if (e == 15) chk("lat.B.Z15", b_if.Z, 4'hF);
         if (e == 16) begin chk("lat.B.Z16", b_if.Z, 4'hD); chk("lat.B.fall16", b_if.fall, 4'h2); end
         if (e == 17) chk("lat.B.fall17", b_if.fall, 4'h0);
      end

      // Glitch on channel 1 for 3 clocks
      pa = 4'b0011;
      repeat (3) begin cyc(); chk("gl.Z", a_if.Z, 4'h1); chk("gl.rise", a_if.rise, 4'h0); end
      pa = 4'b0001;
      repeat (8) begin cyc(); chk("gl.Z", a_if.Z, 4'h1); chk("gl.rise", a_if.rise, 4'h0); end

      // All channels high, then all fall together
      pa = 4'hF;
      repeat (10) cyc();
      chk("all.Zhi", a_if.Z, 4'hF);
      pa = 4'h0; nf = 0;
      repeat (12) begin
         cyc();
         chk("all.rise", a_if.rise, 4'h0);
         if (a_if.fall != 0) begin nf++; chk("all.fall", a_if.fall, 4'hF); end
      end
      chk("all.nfall", nf, 1);
      chk("all.Zlo", a_if.Z, 4'h0);

      // Reset on the edge where channel 0 would have toggled
      pa = 4'b0001;
      repeat (5) cyc();
      reset_n = 1'b0;
      cyc();
      chk("rmid.Z", a_if.Z, 4'h0);
      chk("rmid.rise", a_if.rise, 4'h0);
      reset_n = 1'b1;
      for (int e = 1; e <= 7; e++) begin
         cyc();
         if (e == 1) chk("rmid.rise1", a_if.rise, 4'h0);
         if (e == 5) chk("rmid.Z5", a_if.Z, 4'h0);
         if (e == 6) begin chk("rmid.Z6", a_if.Z, 4'h1); chk("rmid.rise6", a_if.rise, 4'h1); end
      end

      // Bounce train on channel 2, then hold high
      nr = 0;
      for (int i = 0; i < 20; i++) begin
         pa[2] = ~pa[2];
         cyc();
         chk("bnc.Z2", a_if.Z[2], 1'b0);
         nr += a_if.rise[2];
      end
      pa[2] = 1'b1;
      repeat (10) begin cyc(); nr += a_if.rise[2]; end
      chk("bnc.nrise", nr, 1);
      chk("bnc.Zend", a_if.Z, 4'h5);

      // Randomized traffic against the model
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 19) == 0) pa = 4'($urandom);
         if ($urandom_range(0, 39) == 0) pb = 4'($urandom);
         if ($urandom_range(0, 7) == 0)  pa[$urandom_range(0, 3)] ^= 1'b1;
         reset_n = ($urandom_range(0, 599) != 0);
         cyc();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/multi_debouncer.md
MULTI_DEBOUNCER -- requirements
Module: multi_debouncer

Interface
REQ-001 The block SHALL have parameter N, default 4: number of independent debounce channels, legal range 1..32.
REQ-002 The block SHALL have parameter STABLE, default 16: consecutive mismatching ticks required to accept a new level, legal range 1..4096.
REQ-003 The block SHALL have parameter TICK_DIV, default 256: clocks per sample tick, legal range 1..65536.
REQ-004 The block SHALL have parameter RESET_VAL, default 0: the 1-bit level loaded into every channel on reset.
REQ-005 The block SHALL have port clock, input, 1 bit: the single clock; all flops are rising-edge.
REQ-006 The block SHALL have port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-007 The block SHALL have port P, input, N bits: raw asynchronous bouncing inputs, one per channel.
REQ-008 The block SHALL have port Z, output, N bits: registered debounced levels.
REQ-009 The block SHALL have port rise, output, N bits: one-clock pulse when Z[i] goes 0 to 1.
REQ-010 The block SHALL have port fall, output, N bits: one-clock pulse when Z[i] goes 1 to 0.

Function
REQ-011 Each P[i] SHALL pass through a 2-flop synchronizer (s1 <= P, s2 <= s1) clocked every cycle, independent of tick.
REQ-012 A shared prescaler SHALL count 0..TICK_DIV-1 and wrap to 0, with tick high in the cycle the prescaler equals TICK_DIV-1.
REQ-013 When TICK_DIV=1, tick SHALL be constantly high and no prescaler register is required.
REQ-014 Each channel SHALL own a counter of width max(1,$clog2(STABLE)) that saturates at no value above STABLE-1.
REQ-015 On any clock where s2[i]==Z[i], cnt[i] SHALL clear to 0, regardless of tick.
REQ-016 On a tick with s2[i]!=Z[i] and cnt[i]<STABLE-1, cnt[i] SHALL increment by 1.
REQ-017 On a tick with s2[i]!=Z[i] and cnt[i]==STABLE-1, the block SHALL set Z[i] to s2[i] and clear cnt[i] to 0.
REQ-018 On a non-tick clock with s2[i]!=Z[i], cnt[i] SHALL hold its value.
REQ-019 rise[i] and fall[i] SHALL be registered so that each is high exactly in the clock where the new Z[i] is first visible, and low otherwise.
REQ-020 rise[i] and fall[i] SHALL never be high simultaneously.
REQ-021 Channels SHALL be fully independent, so that simultaneous transitions on several channels produce simultaneous pulses.
REQ-022 Latency with TICK_DIV=1: if P[i] changes before rising edge 1 and is held, Z[i] SHALL change on edge STABLE+2.
REQ-023 Latency in general: Z[i] SHALL change at edge 2 plus the STABLE-th tick that follows.
REQ-024 Any mismatch interrupted by one or more clocks with s2[i]==Z[i] SHALL restart the count, so that a glitch held for fewer than STABLE consecutive ticks never changes Z.
REQ-025 The prescaler SHALL free-run and SHALL NOT be restarted by input activity.

Reset
REQ-026 On a rising edge with reset_n==0, the block SHALL load s1, s2 and Z with RESET_VAL on all bits.
REQ-027 On a rising edge with reset_n==0, the block SHALL clear cnt, the prescaler, rise and fall to 0.
REQ-028 Reset SHALL take priority over all other updates, including a reset asserted mid-count or in the same cycle as a pending Z toggle.
REQ-029 Reset SHALL NOT generate rise or fall pulses, either during reset or on the first cycle after release.
REQ-030 After release with P==RESET_VAL, outputs SHALL remain static.

Verification
REQ-031 Stable edge: N=4, STABLE=4, TICK_DIV=1, RESET_VAL=0; P=4'b0001 applied before edge 1 and held -> Z[0]=1 from edge 6, rise[0]=1 for exactly that one clock, other channels stay 0.
REQ-032 Glitch rejection: same config; P[0] high for 3 clocks, then low -> Z stays 0, rise and fall stay 0, cnt[0] returns to 0.
REQ-033 Prescaled timing: STABLE=2, TICK_DIV=8; P[1] rises and is held -> Z[1] rises on the 2nd tick after s2[1] changes, with rise[1] one clock wide.
REQ-034 Fall plus multi-channel: from Z=4'b1111, P=4'b0000 held -> all four fall bits pulse in the same single clock, Z=0, and rise stays 0.
REQ-035 Reset mid-count: reset_n=0 asserted at cnt[0]==STABLE-1 -> next clock Z=0, cnt=0, no pulse; after release, a full STABLE+2 edges are needed again.
REQ-036 Bounce train: P[2] toggles every clock for 20 clocks, then holds 1 -> exactly one rise[2] pulse, and Z[2] stays 0 throughout the bounce.
